// File: rtl/shift_pkg.sv
// Shared encodings and constants for the multi-cycle shift sequencer.
package shift_pkg;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Sequencer states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_SHIFT = 2'b01;
    localparam state_t ST_DONE  = 2'b10;

    localparam int STEP_BIG   = 4;
    localparam int STEP_SMALL = 1;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step: moves data by 4 (big=1) or by 1 (big=0) per op.
module shift_step
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [1:0]            op,
    input  logic                  big,
    output logic [DATA_WIDTH-1:0] shifted
);

    localparam int W = DATA_WIDTH;

    // Select the step result for the requested operation and distance
    always_comb begin
        shifted = data;
        if (big) begin
            case (op)
                OP_LSL:  shifted = {data[W-5:0], 4'b0000};
                OP_LSR:  shifted = {4'b0000, data[W-1:4]};
                OP_ASR:  shifted = {{4{data[W-1]}}, data[W-1:4]};
                OP_ROR:  shifted = {data[3:0], data[W-1:4]};
                default: shifted = data;
            endcase
        end else begin
            case (op)
                OP_LSL:  shifted = {data[W-2:0], 1'b0};
                OP_LSR:  shifted = {1'b0, data[W-1:1]};
                OP_ASR:  shifted = {data[W-1], data[W-1:1]};
                OP_ROR:  shifted = {data[0], data[W-1:1]};
                default: shifted = data;
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle LSL/LSR/ASR/ROR unit: iterates a 4-or-1 step shifter under a
// start/busy/done handshake so the pipeline can stall EX during a shift.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int SHAMT_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [DATA_WIDTH-1:0]  inputData,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  outputData
);

    localparam logic [SHAMT_WIDTH-1:0] BIG_AMT   = SHAMT_WIDTH'(STEP_BIG);
    localparam logic [SHAMT_WIDTH-1:0] SMALL_AMT = SHAMT_WIDTH'(STEP_SMALL);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [1:0]              op_r;
    logic [DATA_WIDTH-1:0]   work_r;
    logic [DATA_WIDTH-1:0]   stepped_s;
    logic [SHAMT_WIDTH-1:0]  remaining_r;
    logic [SHAMT_WIDTH-1:0]  rem_nxt_s;
    logic                    big_s;
    logic                    busy_r;
    logic                    done_r;
    logic                    accept_s;

    shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .data    (work_r),
        .op      (op_r),
        .big     (big_s),
        .shifted (stepped_s)
    );

    // Step size and the count left after this step
    always_comb begin
        big_s     = (remaining_r >= BIG_AMT);
        rem_nxt_s = remaining_r - (big_s ? BIG_AMT : SMALL_AMT);
        accept_s  = start & ~abort;
    end

    // Next-state logic; abort overrides both a new request and progress
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (shamt == {SHAMT_WIDTH{1'b0}}) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (rem_nxt_s == {SHAMT_WIDTH{1'b0}}) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State, handshake flags and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            op_r        <= OP_LSL;
            work_r      <= {DATA_WIDTH{1'b0}};
            remaining_r <= {SHAMT_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            // busy/done come from the next state so they are flops, not decodes
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r        <= op;
                        work_r      <= inputData;
                        remaining_r <= shamt;
                    end
                end
                ST_SHIFT: begin
                    if (!abort) begin
                        work_r      <= stepped_s;
                        remaining_r <= rem_nxt_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign outputData = work_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected results/latencies are queued
// at issue and compared when done pulses.
module tb_shift_sequencer;

    typedef struct {
        logic [63:0] data;
        int          k;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [5:0]  shamt;
    logic [63:0] inputData;
    logic        abort;
    logic        busy;
    logic        done;
    logic [63:0] outputData;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    shift_sequencer #(.DATA_WIDTH(64), .SHAMT_WIDTH(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .shamt      (shamt),
        .inputData  (inputData),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .outputData (outputData)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input int s, input logic [63:0] d);
        logic [63:0] r;
        case (o)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = 64'($signed(d) >>> s);
            default: r = (s == 0) ? d : ((d >> s) | (d << (64 - s)));
        endcase
        return r;
    endfunction

    // Called at a negedge; start is sampled at the next posedge (edge N)
    task automatic issue(input logic [1:0] o, input int s, input logic [63:0] d, input bit expect_done);
        exp_t e;
        start     = 1'b1;
        op        = o;
        shamt     = 6'(s);
        inputData = d;
        if (expect_done) begin
            e.data = model(o, s, d);
            e.k    = (s / 4) + (s % 4);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
    endtask

    // Negedge index c is the cycle after edge N+c; done is due at index k
    task automatic wait_done(input int first);
        exp_t e;
        int   c;
        bit   seen;
        seen = 1'b0;
        c    = first;
        while (c <= 40) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_during_shift: idx %0d got %b want 1", c, busy);
            end
            c++;
        end
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: done seen=%0d with no expectation", seen);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL done_timeout: no done within 40 cycles, want at %0d", e.k);
            end else begin
                checks++;
                if (c != e.k) begin
                    errors++;
                    $display("FAIL latency: got %0d want %0d", c, e.k);
                end
                checks++;
                if (outputData !== e.data) begin
                    errors++;
                    $display("FAIL result: got %h want %h", outputData, e.data);
                end
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_in_done: got %b want 1", busy);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL after_done: busy %b done %b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || outputData !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: busy %b done %b out %h want 0 0 0", busy, done, outputData);
        end
    endtask

    task automatic test_basic_ops();
        issue(2'b00, 5, 64'h1, 1'b1);                 wait_done(0);
        issue(2'b10, 63, 64'h8000_0000_0000_0000, 1'b1); wait_done(0);
        issue(2'b11, 4, 64'h1, 1'b1);                 wait_done(0);
        issue(2'b01, 6, 64'hF0, 1'b1);                wait_done(0);
        issue(2'b01, 0, 64'hDEAD, 1'b1);              wait_done(0);
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 8; i++) begin
            issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 63)),
                  {$urandom, $urandom}, 1'b1);
            wait_done(0);
        end
    endtask

    task automatic test_start_ignored();
        issue(2'b01, 20, 64'hABCD_0000_1234_0000, 1'b1);
        @(negedge clk);
        start     = 1'b1;
        op        = 2'b00;
        shamt     = 6'd1;
        inputData = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(2);
    endtask

    task automatic test_abort();
        // abort together with start in IDLE: not accepted
        start = 1'b1;
        abort = 1'b1;
        shamt = 6'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_with_start: busy %b want 0", busy);
        end
        @(negedge clk);
        issue(2'b00, 20, 64'h5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_to_idle: busy %b done %b want 0 0", busy, done);
        end
        issue(2'b00, 20, 64'h5, 1'b1);
        wait_done(0);
    endtask

    task automatic test_async_reset();
        issue(2'b10, 63, 64'h8000_0000_0000_0001, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || outputData !== 64'h0) begin
            errors++;
            $display("FAIL async_reset: busy %b done %b out %h want 0 0 0", busy, done, outputData);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL spurious_done: idx %0d done %b busy %b want 0 0", i, done, busy);
            end
        end
        issue(2'b00, 1, 64'h3, 1'b1);
        wait_done(0);
    endtask

    task automatic test_back_to_back();
        issue(2'b11, 9, 64'h0123_4567_89AB_CDEF, 1'b1); wait_done(0);
        issue(2'b10, 2, 64'hF000_0000_0000_0010, 1'b1); wait_done(0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        op        = 2'b00;
        shamt     = 6'd0;
        inputData = 64'h0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_ops();
        test_random_ops();
        test_start_ignored();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
